alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits; only 32 is supported.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset, synchronous, active-high.
REQ-004 InValid  input  1  operation request valid.
REQ-005 InReady  output  1  block accepts a request this cycle.
REQ-006 ALUCtrl  input  4  operation code from the ALU control decoder.
REQ-007 BusA  input  WIDTH  operand A (rs).
REQ-008 BusB  input  WIDTH  operand B (rt or immediate).
REQ-009 ShAmt  input  5  shift amount for SLL/SRL/SRA.
REQ-010 OutValid  output  1  Result/Zero/Overflow valid.
REQ-011 OutReady  input  1  consumer takes result this cycle.
REQ-012 Result  output  WIDTH  operation result.
REQ-013 Zero  output  1  high when Result == 0.
REQ-014 Overflow  output  1  signed overflow of ADD/SUB.
REQ-015 AccHi  output  WIDTH  upper accumulator word; constant 0 when MULA_EN is undefined.

Function
REQ-016 Accept occurs when InValid && InReady; ALUCtrl, BusA, BusB, ShAmt are captured at accept.
REQ-017 FSM states: IDLE, SHIFT, MUL, HOLD; InReady = (state==IDLE) || (state==HOLD && OutReady).
REQ-018 Codes AND 0000, OR 0001, ADD 0010, ADDU 1000, SUB 0110, SUBU 1001, XOR 1010, NOR 1100, SLT 0111, SLTU 1011, LUI 1110 complete in one cycle: OutValid high the cycle after accept, state -> HOLD.
REQ-019 SLL 0011, SRL 0100, SRA 1101 shift BusB by ShAmt one bit per cycle in SHIFT; OutValid rises ShAmt+1 cycles after accept; ShAmt=0 gives 1-cycle latency.
REQ-020 SRA replicates BusB[31]; SLL/SRL fill with 0.
REQ-021 ADD/SUB: Overflow = signed overflow, wrap-around result still written; all other ops Overflow=0.
REQ-022 SLT signed compare, SLTU unsigned compare; Result = {31'b0, less}.
REQ-023 LUI: Result = {BusB[15:0], 16'h0000}.
REQ-024 RTYP 1111 and any unassigned code: Result=0, Zero=1, Overflow=0, 1-cycle latency, no hang.
REQ-025 HOLD: Result/Zero/Overflow/OutValid stable until OutReady; OutReady && InValid in HOLD accepts next op with no bubble (back-to-back throughput 1/cycle for 1-cycle ops).
REQ-026 HOLD && OutReady && !InValid -> IDLE, OutValid low next cycle.
REQ-027 InValid ignored in SHIFT and MUL; inputs changing there do not affect the op in progress.

Reset
REQ-028 Reset high at any edge, including mid-SHIFT/MUL, forces IDLE, OutValid=0, Result=0, Zero=0, Overflow=0, AccHi=0, accumulator=0; in-flight op discarded.
REQ-029 InReady=1 in the first cycle after Reset deasserts.

Configuration
REQ-030 Macro ALU_EXEC_MULA_EN defined: code 0101 (MULA) does unsigned 32x32 shift-add, accumulates into 64-bit {AccHi,Result-Lo}, MUL state 32 cycles, OutValid 33 cycles after accept; Result = new low word, AccHi = new high word, 64-bit wrap-around, Overflow=0.
REQ-031 Macro undefined: 0101 behaves per REQ-024, MUL state and accumulator absent, AccHi tied 0.

Structure
REQ-032 Package alu_pkg holds ALUCtrl code constants, WIDTH default, FSM state encoding; shared with the ALU control decoder.
REQ-033 Sub-module alu_shifter holds the iterative shift register and count; FSM, arithmetic and handshake stay in alu_exec.

Verification
REQ-034 ADD BusA=0x7FFFFFFF, BusB=1, OutReady=1 -> next cycle Result=0x80000000, Overflow=1, Zero=0; ADDU same operands -> Overflow=0.
REQ-035 SRA BusB=0x80000000, ShAmt=31 -> OutValid exactly 32 cycles after accept, Result=0xFFFFFFFF; ShAmt=0 -> 1 cycle, Result=BusB.
REQ-036 SUB 5-5 with OutReady=0 for 4 cycles -> Result=0, Zero=1 held stable, InReady=0 until OutReady; then back-to-back SLT -1<1 and SLTU 0xFFFFFFFF<1 -> Result 1 then 0 on consecutive cycles.
REQ-037 Reset asserted 3 cycles into SLL ShAmt=20 -> OutValid=0, Result=0 next cycle, InReady=1 after release, no stale result emitted.
REQ-038 ALU_EXEC_MULA_EN: two MULA 0xFFFFFFFF*2 -> after second, {AccHi,Result}=0x00000003_FFFFFFFC, each 33-cycle latency; without macro code 0101 -> Result=0, Zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, default width, exec FSM and shifter encodings.
// Also used by the ALU control decoder.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND  = 4'b0000;
  localparam alu_ctrl_t ALU_OR   = 4'b0001;
  localparam alu_ctrl_t ALU_ADD  = 4'b0010;
  localparam alu_ctrl_t ALU_SLL  = 4'b0011;
  localparam alu_ctrl_t ALU_SRL  = 4'b0100;
  localparam alu_ctrl_t ALU_MULA = 4'b0101;
  localparam alu_ctrl_t ALU_SUB  = 4'b0110;
  localparam alu_ctrl_t ALU_SLT  = 4'b0111;
  localparam alu_ctrl_t ALU_ADDU = 4'b1000;
  localparam alu_ctrl_t ALU_SUBU = 4'b1001;
  localparam alu_ctrl_t ALU_XOR  = 4'b1010;
  localparam alu_ctrl_t ALU_SLTU = 4'b1011;
  localparam alu_ctrl_t ALU_NOR  = 4'b1100;
  localparam alu_ctrl_t ALU_SRA  = 4'b1101;
  localparam alu_ctrl_t ALU_LUI  = 4'b1110;
  localparam alu_ctrl_t ALU_RTYP = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_HOLD} alu_state_e;

  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} sh_mode_e;

  function automatic logic is_shift(input alu_ctrl_t c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter; o_next is the value after the next step and
// o_last flags that the pending step is the final one.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  sh_mode_e         i_mode,
  input  logic [WIDTH-1:0] i_data,
  input  logic [4:0]       i_amt,
  output logic [WIDTH-1:0] o_next,
  output logic             o_last
);

  logic [WIDTH-1:0] r_data;
  logic [4:0]       r_cnt;
  sh_mode_e         r_mode;

  always_comb begin
    case (r_mode)
      SH_SLL:  o_next = {r_data[WIDTH-2:0], 1'b0};
      SH_SRL:  o_next = {1'b0, r_data[WIDTH-1:1]};
      default: o_next = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
    endcase
  end

  assign o_last = (r_cnt == 5'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_mode <= SH_SLL;
    end else if (i_load) begin
      r_data <= i_data;
      r_cnt  <= i_amt;
      r_mode <= i_mode;
    end else if (r_cnt != 5'd0) begin
      r_data <= o_next;
      r_cnt  <= r_cnt - 5'd1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Handshaked ALU execute stage with iterative shifts. Define ALU_EXEC_MULA_EN to add the
// 32-cycle multiply-accumulate (code 0101) with a 64-bit accumulator.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [4:0]       ShAmt,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic [WIDTH-1:0] AccHi
);

  alu_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_result, w_alu_res, w_sum, w_diff, w_sh_next;
  logic             r_zero, r_ovf, w_alu_ovf, w_accept, w_sh_last, w_sh_load;
  sh_mode_e         w_sh_mode;

  assign InReady  = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && OutReady);
  assign OutValid = (r_state == ST_HOLD);
  assign w_accept = InValid && InReady;
  assign Result   = r_result;
  assign Zero     = r_zero;
  assign Overflow = r_ovf;
  assign w_sum    = BusA + BusB;
  assign w_diff   = BusA - BusB;

  // Single-cycle results; a shift with ShAmt=0 simply passes BusB through.
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (ALUCtrl)
      ALU_AND:  w_alu_res = BusA & BusB;
      ALU_OR:   w_alu_res = BusA | BusB;
      ALU_XOR:  w_alu_res = BusA ^ BusB;
      ALU_NOR:  w_alu_res = ~(BusA | BusB);
      ALU_ADDU: w_alu_res = w_sum;
      ALU_SUBU: w_alu_res = w_diff;
      ALU_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (BusA[WIDTH-1] == BusB[WIDTH-1]) && (w_sum[WIDTH-1] != BusA[WIDTH-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (BusA[WIDTH-1] != BusB[WIDTH-1]) && (w_diff[WIDTH-1] != BusA[WIDTH-1]);
      end
      ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(BusA) < $signed(BusB))};
      ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (BusA < BusB)};
      ALU_LUI:  w_alu_res = {BusB[15:0], 16'h0000};
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = BusB;
      default:  w_alu_res = '0;
    endcase
  end

  always_comb begin
    case (ALUCtrl)
      ALU_SLL: w_sh_mode = SH_SLL;
      ALU_SRL: w_sh_mode = SH_SRL;
      default: w_sh_mode = SH_SRA;
    endcase
  end

  assign w_sh_load = w_accept && is_shift(ALUCtrl);

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .i_clk  (CLK),
    .i_rst  (Reset),
    .i_load (w_sh_load),
    .i_mode (w_sh_mode),
    .i_data (BusB),
    .i_amt  (ShAmt),
    .o_next (w_sh_next),
    .o_last (w_sh_last)
  );

`ifdef ALU_EXEC_MULA_EN
  logic [2*WIDTH-1:0] r_mcand, r_prod, r_acc, w_prod_nxt, w_acc_nxt;
  logic [WIDTH-1:0]   r_mplier;
  logic [5:0]         r_mcnt;
  logic               w_mul_done;

  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_acc_nxt  = r_acc + w_prod_nxt;
  assign w_mul_done = (r_state == ST_MUL) && (r_mcnt == 6'd1);
  assign AccHi      = r_acc[2*WIDTH-1:WIDTH];

  // Shift-add: one multiplier bit per cycle, folded into the accumulator on the last step.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_mcnt   <= '0;
    end else if (w_accept && (ALUCtrl == ALU_MULA)) begin
      r_mcand  <= {{WIDTH{1'b0}}, BusA};
      r_mplier <= BusB;
      r_prod   <= '0;
      r_mcnt   <= 6'd32;
    end else if (r_state == ST_MUL) begin
      r_prod   <= w_prod_nxt;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_mcnt   <= r_mcnt - 6'd1;
      if (w_mul_done) r_acc <= w_acc_nxt;
    end
  end
`else
  assign AccHi = '0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_accept) begin
          if (is_shift(ALUCtrl) && (ShAmt != 5'd0)) w_state_nxt = ST_SHIFT;
`ifdef ALU_EXEC_MULA_EN
          else if (ALUCtrl == ALU_MULA)            w_state_nxt = ST_MUL;
`endif
          else                                      w_state_nxt = ST_HOLD;
        end else if (r_state == ST_HOLD && OutReady) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: if (w_sh_last) w_state_nxt = ST_HOLD;
`ifdef ALU_EXEC_MULA_EN
      ST_MUL:   if (w_mul_done) w_state_nxt = ST_HOLD;
`endif
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_result <= w_alu_res;
      r_zero   <= (w_alu_res == '0);
      r_ovf    <= w_alu_ovf;
    end else if ((r_state == ST_SHIFT) && w_sh_last) begin
      r_result <= w_sh_next;
      r_zero   <= (w_sh_next == '0);
      r_ovf    <= 1'b0;
    end
`ifdef ALU_EXEC_MULA_EN
    else if (w_mul_done) begin
      r_result <= w_acc_nxt[WIDTH-1:0];
      r_zero   <= (w_acc_nxt[WIDTH-1:0] == '0);
      r_ovf    <= 1'b0;
    end
`endif
  end

endmodule
